// File: rtl/up_down_counter_sequencer_if.sv
// Command and counter-control bundle for up_down_counter_sequencer.
// slave: the sequencer. master: the requester together with the counter.
interface up_down_counter_sequencer_if #(
    parameter int N = 4,
    parameter int W = 8
);
    logic         start;
    logic         cmd_up;
    logic [N-1:0] cmd_load;
    logic [W-1:0] cmd_wraps;
    logic         abort;
    logic         ready;
    logic         done;
    logic         err;
    logic [W-1:0] wrap_cnt;
    logic         en_b;
    logic         load_b;
    logic         up;
    logic [N-1:0] load_in;
    logic         rco_b;

    modport slave (
        input  start, cmd_up, cmd_load, cmd_wraps, abort, rco_b,
        output ready, done, err, wrap_cnt, en_b, load_b, up, load_in
    );

    modport master (
        output start, cmd_up, cmd_load, cmd_wraps, abort, rco_b,
        input  ready, done, err, wrap_cnt, en_b, load_b, up, load_in
    );
endinterface

// File: rtl/up_down_counter_sequencer.sv
// Sequencer for an up_down_counter: loads a start value, enables counting,
// counts rco_b assertions until the requested number of wraps, then pulses done.
// Optional watchdog: define UP_DOWN_COUNTER_SEQUENCER_WATCHDOG_EN to abort a RUN
// that sees no rco_b for 2^N+1 enabled cycles (done with err=1).
module up_down_counter_sequencer #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                        clk,
    input  logic                        rst_b,
    up_down_counter_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t       state_q, state_d;
    logic         up_q, up_d;
    logic [N-1:0] load_q, load_d;
    logic [W-1:0] wraps_q, wraps_d;
    logic [W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic [W-1:0] wrap_inc;

`ifdef UP_DOWN_COUNTER_SEQUENCER_WATCHDOG_EN
    localparam logic [N:0] WD_LIMIT = (N+1)'((1 << N) + 1);
    logic [N:0]   wd_q, wd_d;
    logic [N:0]   wd_inc;
    logic         err_q, err_d;
`endif

    assign wrap_inc = wrap_cnt_q + W'(1);
`ifdef UP_DOWN_COUNTER_SEQUENCER_WATCHDOG_EN
    assign wd_inc   = wd_q + (N+1)'(1);
`endif

    // Next-state and command/status register updates.
    always_comb begin
        state_d    = state_q;
        up_d       = up_q;
        load_d     = load_q;
        wraps_d    = wraps_q;
        wrap_cnt_d = wrap_cnt_q;
`ifdef UP_DOWN_COUNTER_SEQUENCER_WATCHDOG_EN
        wd_d       = wd_q;
        err_d      = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d    = S_LOAD;
                    up_d       = bus.cmd_up;
                    load_d     = bus.cmd_load;
                    wraps_d    = bus.cmd_wraps;
                    wrap_cnt_d = '0;
`ifdef UP_DOWN_COUNTER_SEQUENCER_WATCHDOG_EN
                    err_d      = 1'b0;
`endif
                end
            end
            S_LOAD: begin
`ifdef UP_DOWN_COUNTER_SEQUENCER_WATCHDOG_EN
                wd_d = '0;
`endif
                if (bus.abort)
                    state_d = S_IDLE;
                else if (wraps_q == '0)
                    state_d = S_DONE;
                else
                    state_d = S_RUN;
            end
            S_RUN: begin
                if (!bus.rco_b)
                    wrap_cnt_d = wrap_inc;
`ifdef UP_DOWN_COUNTER_SEQUENCER_WATCHDOG_EN
                wd_d = bus.rco_b ? wd_inc : '0;
`endif
                // abort outranks both a terminal wrap and a watchdog expiry
                if (bus.abort)
                    state_d = S_IDLE;
                else if (!bus.rco_b && (wrap_inc == wraps_q))
                    state_d = S_DONE;
`ifdef UP_DOWN_COUNTER_SEQUENCER_WATCHDOG_EN
                else if (bus.rco_b && (wd_inc == WD_LIMIT)) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end
`endif
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and command/status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q    <= S_IDLE;
            up_q       <= 1'b1;
            load_q     <= '0;
            wraps_q    <= '0;
            wrap_cnt_q <= '0;
`ifdef UP_DOWN_COUNTER_SEQUENCER_WATCHDOG_EN
            wd_q       <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            up_q       <= up_d;
            load_q     <= load_d;
            wraps_q    <= wraps_d;
            wrap_cnt_q <= wrap_cnt_d;
`ifdef UP_DOWN_COUNTER_SEQUENCER_WATCHDOG_EN
            wd_q       <= wd_d;
            err_q      <= err_d;
`endif
        end
    end

    assign bus.ready    = (state_q == S_IDLE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.en_b     = (state_q != S_RUN);
    assign bus.load_b   = (state_q != S_LOAD);
    assign bus.up       = up_q;
    assign bus.load_in  = load_q;
    assign bus.wrap_cnt = wrap_cnt_q;
`ifdef UP_DOWN_COUNTER_SEQUENCER_WATCHDOG_EN
    assign bus.err      = err_q;
`else
    assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_up_down_counter_sequencer.sv
// Self-checking bench for up_down_counter_sequencer with a behavioural
// up_down_counter attached; expected command results go through a scoreboard.
module tb_up_down_counter_sequencer;

    localparam int N = 4;
    localparam int W = 8;
    localparam logic [N-1:0] TC_UP = '1;
    localparam logic [N-1:0] TC_DN = '0;

    logic clk;
    logic rst_b;
    logic rco_force;
    logic [N-1:0] q;

    int unsigned vectors;
    int unsigned miscompares;

    typedef struct {
        int unsigned runs;
        logic [W-1:0] wraps;
        logic [N-1:0] qv;
        logic err;
        logic up;
    } exp_t;
    exp_t sb[$];

    up_down_counter_sequencer_if #(.N(N), .W(W)) bus ();

    up_down_counter_sequencer #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural up_down_counter
    always @(posedge clk) begin
        if (!bus.load_b)
            q <= bus.load_in;
        else if (!bus.en_b)
            q <= bus.up ? q + 1'b1 : q - 1'b1;
    end

    always_comb begin
        bus.rco_b = 1'b1;
        if (!bus.en_b && (q == (bus.up ? TC_UP : TC_DN)))
            bus.rco_b = 1'b0;
        if (rco_force)
            bus.rco_b = 1'b1;
    end

    function automatic int unsigned exp_runs(bit u, int unsigned l, int unsigned w);
        if (w == 0) return 0;
        return (u ? ((2**N) - 1 - l) : l) + 1 + (w - 1) * (2**N);
    endfunction

    // Issue a command from IDLE; leaves the bench at the LOAD-cycle negedge.
    task automatic issue_cmd(input bit u, input int unsigned l, input int unsigned w, input bit push);
        exp_t e;
        @(negedge clk);
        vectors++;
        if (bus.ready !== 1'b1) begin
            miscompares++;
            $display("FAIL issue_ready: got %b want 1", bus.ready);
        end
        bus.start     = 1'b1;
        bus.cmd_up    = u;
        bus.cmd_load  = N'(l);
        bus.cmd_wraps = W'(w);
        if (push) begin
            e.runs  = exp_runs(u, l, w);
            e.wraps = W'(w);
            e.qv    = (w == 0) ? N'(l) : (u ? TC_UP + 1'b1 : TC_UP);
            e.err   = 1'b0;
            e.up    = u;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
        vectors++;
        if ({bus.ready, bus.en_b, bus.load_b, bus.up, bus.load_in} !== {1'b0, 1'b1, 1'b0, u, N'(l)}) begin
            miscompares++;
            $display("FAIL load_cycle: got %b want %b",
                     {bus.ready, bus.en_b, bus.load_b, bus.up, bus.load_in}, {1'b0, 1'b1, 1'b0, u, N'(l)});
        end
    endtask

    // Follow a command to its done pulse and check against the scoreboard.
    // poke_at>0 pulses a conflicting start on that cycle count.
    task automatic complete_cmd(input string name, input int unsigned poke_at);
        int unsigned runs = 0;
        int unsigned t = 1;
        bit up_bad = 1'b0;
        bit seen = 1'b0;
        exp_t e;
        e.runs = 0; e.wraps = '0; e.qv = '0; e.err = 1'b0; e.up = 1'b1;
        if (sb.size() != 0) e = sb.pop_front();
        else begin
            miscompares++;
            $display("FAIL %s_sb: scoreboard empty", name);
        end
        while (t < 3000) begin
            @(negedge clk);
            t++;
            if (poke_at != 0 && t == poke_at) begin
                bus.start = 1'b1; bus.cmd_up = ~e.up; bus.cmd_load = 3; bus.cmd_wraps = 9;
            end
            if (poke_at != 0 && t == poke_at + 1) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (bus.en_b === 1'b0) runs++;
            if (bus.up !== e.up) up_bad = 1'b1;
        end
        bus.start = 1'b0;
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL %s_timeout: no done after %0d cycles", name, t);
            return;
        end
        vectors++;
        if (runs !== e.runs) begin
            miscompares++;
            $display("FAIL %s_runs: got %0d want %0d", name, runs, e.runs);
        end
        vectors++;
        if (t !== e.runs + 2) begin
            miscompares++;
            $display("FAIL %s_latency: got %0d want %0d", name, t, e.runs + 2);
        end
        vectors++;
        if ({bus.wrap_cnt, bus.err} !== {e.wraps, e.err}) begin
            miscompares++;
            $display("FAIL %s_status: wrap_cnt/err got %0d/%b want %0d/%b", name, bus.wrap_cnt, bus.err, e.wraps, e.err);
        end
        vectors++;
        if (up_bad || q !== e.qv) begin
            miscompares++;
            $display("FAIL %s_counter: q got %0d want %0d, up_changed=%b", name, q, e.qv, up_bad);
        end
        @(negedge clk);
        vectors++;
        if ({bus.ready, bus.done, bus.en_b, q} !== {1'b1, 1'b0, 1'b1, e.qv}) begin
            miscompares++;
            $display("FAIL %s_after: ready/done/en_b/q got %b want %b", name,
                     {bus.ready, bus.done, bus.en_b, q}, {1'b1, 1'b0, 1'b1, e.qv});
        end
    endtask

    task automatic check_reset_vals(input string name);
        vectors++;
        if ({bus.ready, bus.done, bus.err, bus.wrap_cnt, bus.en_b, bus.load_b, bus.up, bus.load_in}
            !== {1'b1, 1'b0, 1'b0, W'(0), 1'b1, 1'b1, 1'b1, N'(0)}) begin
            miscompares++;
            $display("FAIL %s: got %b want %b", name,
                     {bus.ready, bus.done, bus.err, bus.wrap_cnt, bus.en_b, bus.load_b, bus.up, bus.load_in},
                     {1'b1, 1'b0, 1'b0, W'(0), 1'b1, 1'b1, 1'b1, N'(0)});
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_b = 1'b1;
        // abort in IDLE has no effect
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check_reset_vals("abort_idle");
    endtask

    task automatic test_up_down();
        issue_cmd(1'b1, 0, 1, 1'b1);
        complete_cmd("up_l0_w1", 0);
        issue_cmd(1'b0, 10, 2, 1'b1);
        complete_cmd("down_l10_w2", 0);
        issue_cmd(1'b1, 13, 3, 1'b1);
        complete_cmd("up_l13_w3", 0);
        issue_cmd(1'b0, 0, 1, 1'b1);
        complete_cmd("down_l0_w1", 0);
    endtask

    task automatic test_zero_wraps();
        issue_cmd(1'b1, 10, 0, 1'b1);
        complete_cmd("zero_wraps", 0);
    endtask

    task automatic test_start_in_run();
        issue_cmd(1'b1, 2, 2, 1'b1);
        complete_cmd("start_in_run", 6);
    endtask

    task automatic test_abort_on_wrap();
        int unsigned n = 0;
        issue_cmd(1'b1, 14, 3, 1'b0);
        while (n < 40 && !(bus.en_b === 1'b0 && bus.rco_b === 1'b0)) begin
            @(negedge clk);
            n++;
        end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        vectors++;
        if ({bus.ready, bus.done, bus.en_b, bus.wrap_cnt} !== {1'b1, 1'b0, 1'b1, W'(1)}) begin
            miscompares++;
            $display("FAIL abort_wrap: ready/done/en_b/wrap_cnt got %b want %b",
                     {bus.ready, bus.done, bus.en_b, bus.wrap_cnt}, {1'b1, 1'b0, 1'b1, W'(1)});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({bus.done, bus.wrap_cnt} !== {1'b0, W'(1)}) begin
                miscompares++;
                $display("FAIL abort_hold: done/wrap_cnt got %b want %b", {bus.done, bus.wrap_cnt}, {1'b0, W'(1)});
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int unsigned n = 0;
        issue_cmd(1'b1, 0, 5, 1'b0);
        while (n < 200 && bus.wrap_cnt !== W'(3)) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (bus.en_b !== 1'b0 || bus.wrap_cnt !== W'(3)) begin
            miscompares++;
            $display("FAIL mid_run_reach: en_b/wrap_cnt got %b/%0d want 0/3", bus.en_b, bus.wrap_cnt);
        end
        rst_b = 1'b0;
        @(negedge clk);
        check_reset_vals("reset_mid_run");
        rst_b = 1'b1;
        issue_cmd(1'b0, 5, 1, 1'b1);
        complete_cmd("after_reset", 0);
    endtask

    task automatic test_watchdog();
`ifdef UP_DOWN_COUNTER_SEQUENCER_WATCHDOG_EN
        exp_t e;
        issue_cmd(1'b1, 0, 1, 1'b0);
        rco_force = 1'b1;
        e.runs = 17; e.wraps = '0; e.qv = N'(17); e.err = 1'b1; e.up = 1'b1;
        sb.push_back(e);
        complete_cmd("watchdog", 0);
        rco_force = 1'b0;
        vectors++;
        if (bus.err !== 1'b1) begin
            miscompares++;
            $display("FAIL watchdog_err_hold: got %b want 1", bus.err);
        end
        issue_cmd(1'b1, 15, 1, 1'b1);
        complete_cmd("watchdog_clear", 0);
`else
        bit done_seen = 1'b0;
        issue_cmd(1'b1, 0, 1, 1'b0);
        rco_force = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_seen = 1'b1;
        end
        vectors++;
        if ({done_seen, bus.err, bus.en_b} !== 3'b000) begin
            miscompares++;
            $display("FAIL no_watchdog: done_seen/err/en_b got %b want 000", {done_seen, bus.err, bus.en_b});
        end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        rco_force = 1'b0;
        vectors++;
        if ({bus.ready, bus.done} !== 2'b10) begin
            miscompares++;
            $display("FAIL no_watchdog_abort: ready/done got %b want 10", {bus.ready, bus.done});
        end
`endif
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rco_force     = 1'b0;
        rst_b         = 1'b0;
        bus.start     = 1'b0;
        bus.cmd_up    = 1'b0;
        bus.cmd_load  = '0;
        bus.cmd_wraps = '0;
        bus.abort     = 1'b0;
        test_reset();
        test_up_down();
        test_zero_wraps();
        test_start_in_run();
        test_abort_on_wrap();
        test_reset_mid_run();
        test_watchdog();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
